// File: rtl/fifo_wr_arbiter_if.sv
// Producer and FIFO-write-side signal bundle for fifo_wr_arbiter.
// The slave modport is the arbiter; the master modport is the surrounding environment.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_alm_full;
  logic                      fifo_wren;
  logic [DATA_W-1:0]         fifo_wrdata;
  logic                      grant_valid;
  logic [ID_W-1:0]           grant_id;

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_alm_full,
    output req_ready, fifo_wren, fifo_wrdata, grant_valid, grant_id
  );

  modport master (
    output req_valid, req_data, fifo_full, fifo_alm_full,
    input  req_ready, fifo_wren, fifo_wrdata, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
// Optional FIFO_WR_ARB_ALM_FULL_THROTTLE_EN makes fifo_alm_full block new grants and end bursts early.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rstn,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]    next_id;
  logic               found;
  logic               grant_ok;
  logic               throttle;
  logic [NUM_REQ-1:0] ready;
  logic               wren;
  logic [DATA_W-1:0]  wrdata;
  logic               release_grant;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    found   = 1'b0;
    next_id = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && bus.req_valid[(int'(last_grant_q) + i) % NUM_REQ]) begin
        found   = 1'b1;
        next_id = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
      end
    end
  end

`ifdef FIFO_WR_ARB_ALM_FULL_THROTTLE_EN
  assign throttle = bus.fifo_alm_full;
`else
  assign throttle = 1'b0;
`endif

  assign grant_ok = found & ~throttle;

  // The owner's handshake drives the FIFO write directly, so an accepted beat costs no latency.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise unassigned paths infer latches.
    ready  = '0;
    wren   = 1'b0;
    wrdata = '0;
    if (state_q == BURST) begin
      ready[grant_id_q] = ~bus.fifo_full;
      wren              = bus.req_valid[grant_id_q] & ~bus.fifo_full;
      if (wren) wrdata = bus.req_data[int'(grant_id_q)*DATA_W +: DATA_W];
    end
  end

  assign bus.req_ready   = ready;
  assign bus.fifo_wren   = wren;
  assign bus.fifo_wrdata = wrdata;
  assign bus.grant_valid = (state_q == BURST);
  assign bus.grant_id    = grant_id_q;

  // Dropping valid releases even while stalled on fifo_full, so a stalled idle owner cannot hog the port.
  assign release_grant = ~bus.req_valid[grant_id_q]
                       | (wren & (beat_cnt_q == CNT_W'(BURST_LEN - 1)))
                       | (wren & throttle);

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          state_d    = BURST;
          grant_id_d = next_id;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (wren) beat_cnt_d = beat_cnt_q + 1'b1;
        if (release_grant) begin
          state_d      = IDLE;
          last_grant_d = grant_id_q;
          beat_cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end
endmodule
